// File: rtl/chunk_reassembler_pkg.sv
// rtl/chunk_reassembler_pkg.sv - shared derivations and state type for the chunk reassembler
package chunk_reassembler_pkg;

    // Rounds a / b up to the next integer.
    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Chunk counter width: enough to index NUM_CHUNKS chunks, never narrower than one bit.
    function automatic int cnt_width(input int num_chunks);
        return (num_chunks > 1) ? $clog2(num_chunks) : 1;
    endfunction

    typedef enum logic {
        IDLE,
        ASSEMBLE
    } asm_state_e;

endpackage

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - synchronous first-word-fall-through FIFO with wrap-bit pointers
module word_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Pointer update; the extra top bit distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because empty masks the output.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/chunk_reassembler.sv
// rtl/chunk_reassembler.sv - rebuilds WORD_W words from narrow chunks; optional CHUNK_REASSEMBLER_TIMEOUT_EN
module chunk_reassembler
    import chunk_reassembler_pkg::*;
#(
    parameter int CHUNK_W        = 4,
    parameter int WORD_W         = 8,
    parameter int FIFO_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sync_clr,
    input  logic               chunk_valid,
    input  logic [CHUNK_W-1:0] chunk_data,
    output logic               chunk_ready,
    output logic               word_valid,
    output logic [WORD_W-1:0]  word_data,
    input  logic               word_ready,
    output logic               overflow,
    output logic               timeout_err
);

    localparam int NUM_CHUNKS = ceil_div(WORD_W, CHUNK_W);
    localparam int CNT_W      = cnt_width(NUM_CHUNKS);
    localparam int ASM_W      = NUM_CHUNKS * CHUNK_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CHUNKS - 1);

    asm_state_e       state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_n;
    logic [ASM_W-1:0] asm_reg;
    logic [ASM_W-1:0] asm_n;
    logic [ASM_W-1:0] merged;
    logic             overflow_n;
    logic             push;
    logic             pop;
    logic             wr_en;
    logic             full;
    logic             empty;

`ifdef CHUNK_REASSEMBLER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0] idle_cnt;
    logic [IDLE_W-1:0] idle_n;
    logic              expire;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

    assign state       = (count == '0) ? IDLE : ASSEMBLE;
    assign pop         = word_ready && !empty;
    assign wr_en       = push && (!full || pop);
    assign chunk_ready = !full;
    assign word_valid  = !empty;

    // Overlay the incoming chunk onto its slot of the assembly register.
    always_comb begin
        merged = asm_reg;
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            if (count == CNT_W'(k)) merged[k*CHUNK_W +: CHUNK_W] = chunk_data;
        end
    end

    // Next-state: chunk counting, word completion, overflow and idle expiry.
    always_comb begin
        count_n    = count;
        asm_n      = asm_reg;
        overflow_n = overflow;
        push       = 1'b0;
`ifdef CHUNK_REASSEMBLER_TIMEOUT_EN
        idle_n     = idle_cnt;
        expire     = 1'b0;
`endif
        if (sync_clr) begin
            count_n    = '0;
            overflow_n = 1'b0;
`ifdef CHUNK_REASSEMBLER_TIMEOUT_EN
            idle_n     = '0;
`endif
        end else if (chunk_valid) begin
            asm_n = merged;
`ifdef CHUNK_REASSEMBLER_TIMEOUT_EN
            idle_n = '0;
`endif
            if (count == LAST) begin
                count_n = '0;
                push    = 1'b1;
                if (full && !pop) overflow_n = 1'b1;
            end else begin
                count_n = count + 1'b1;
            end
        end
`ifdef CHUNK_REASSEMBLER_TIMEOUT_EN
        else if (state == ASSEMBLE) begin
            if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                count_n = '0;
                idle_n  = '0;
                expire  = 1'b1;
            end else begin
                idle_n = idle_cnt + 1'b1;
            end
        end
`endif
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            asm_reg  <= '0;
            overflow <= 1'b0;
        end else begin
            count    <= count_n;
            asm_reg  <= asm_n;
            overflow <= overflow_n;
        end
    end

`ifdef CHUNK_REASSEMBLER_TIMEOUT_EN
    // Idle counter and the one-cycle discard pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            idle_cnt    <= idle_n;
            timeout_err <= expire;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (merged[WORD_W-1:0]),
        .rd_en   (pop),
        .rd_data (word_data),
        .full    (full),
        .empty   (empty)
    );

endmodule

// File: doc/chunk_reassembler.md
# chunk_reassembler

Receive-side counterpart of the width arbitrator's parallel-to-serial path: collects a stream of narrow CHUNK_W chunks (least-significant chunk first, no upstream backpressure) and rebuilds full WORD_W words. Completed words are buffered in a small FIFO and presented downstream on a valid/ready interface. Sits at the far end of a narrow link, in front of any wide-word consumer.

## Interface
- CHUNK_W, default 4: chunk width in bits; must be less than WORD_W.
- WORD_W, default 8: reassembled word width in bits.
- FIFO_DEPTH, default 2: word buffer depth; power of two, at least 2.
- TIMEOUT_CYCLES, default 16: idle cycles before a partial word is discarded (used only with the timeout feature).

- clk  in  1  clock, all logic on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- sync_clr  in  1  synchronous clear of the partial word and the sticky flags; the FIFO is untouched.
- chunk_valid  in  1  chunk present; accepted unconditionally.
- chunk_data  in  CHUNK_W  chunk payload.
- chunk_ready  out  1  advisory: FIFO not full.
- word_valid  out  1  FIFO non-empty.
- word_data  out  WORD_W  head FIFO word, first-word fall-through.
- word_ready  in  1  consumer accepts the head word.
- overflow  out  1  sticky; a completed word was dropped.
- timeout_err  out  1  one-cycle pulse; a partial word was discarded.

## Operation
- NUM_CHUNKS = ceil(WORD_W / CHUNK_W); the chunk counter is $clog2(NUM_CHUNKS) bits wide, minimum 1.
- Chunk k fills bits [k*CHUNK_W +: CHUNK_W] of the assembly register.
- For the final chunk, bits at or above WORD_W are discarded.
- States:
  - IDLE (count == 0).
  - ASSEMBLE (0 < count < NUM_CHUNKS).
- Each accepted chunk increments count.
- On the chunk where count == NUM_CHUNKS-1, the completed word is pushed to the FIFO and count returns to 0.
- The pushed word is built from the register contents merged with the current chunk.
- Push when FIFO is full and no pop in the same cycle: the word is dropped, overflow is set, and count still returns to 0.
- Push when FIFO is full with a pop (word_ready && word_valid) in the same cycle: the push succeeds and occupancy is unchanged.
- A pop occurs on word_valid && word_ready.
- word_valid and word_data are stable while word_valid=1 and word_ready=0.
- sync_clr:
  - Forces count to 0 and clears overflow.
  - If it coincides with chunk_valid, the chunk is discarded.
  - A pop in the same cycle still completes.
- The FIFO uses read/write pointers with one extra wrap bit; full and empty are decoded from the pointers.

## Timing
- Reset values:
  - word_valid=0, word_data=0, overflow=0, timeout_err=0, chunk_ready=1.
  - count=0, FIFO empty, assembly register 0.
- Latency: the last chunk sampled at edge N gives word_valid=1 after edge N, i.e. one cycle.
- Back-to-back chunks are accepted every cycle; sustained throughput is one word per NUM_CHUNKS cycles.
- chunk_ready and word_valid are registered-state decodes with no combinational path from chunk_valid.
- word_ready feeds only the pop logic.
- Reset asserted mid-assembly discards the partial word and empties the FIFO immediately.

## Configuration
- Macro: CHUNK_REASSEMBLER_TIMEOUT_EN.
- Defined:
  - An idle counter clears on every accepted chunk and counts cycles spent in ASSEMBLE with chunk_valid=0.
  - When it reaches TIMEOUT_CYCLES, count goes to 0 and timeout_err pulses high for exactly one cycle.
  - A chunk arriving in the expiry cycle is treated as chunk 0 of a new word.
- Undefined: timeout_err is tied to 0 and a partial word is held indefinitely.

## Structure
- Package chunk_reassembler_pkg holds:
  - the ceiling-divide function;
  - the NUM_CHUNKS and count-width derivation;
  - the state enum (IDLE, ASSEMBLE).
- Sub-module word_fifo: synchronous FWFT FIFO, parameterised by width and depth, with full/empty outputs; it owns the pointers and storage.

## Test plan
- CHUNK_W=4, WORD_W=8; chunks 0x5, 0xA on consecutive cycles -> word_data=0xA5 with word_valid one cycle after the second chunk.
- CHUNK_W=4, WORD_W=10; chunks 0x3, 0x2, 0xF -> word_data=0x323 (top chunk truncated to 2 bits).
- word_ready=0, FIFO_DEPTH=2, three words 0x11, 0x22, 0x33 -> FIFO holds 0x11, 0x22; overflow=1; chunk_ready=0. Then word_ready=1 -> 0x11 then 0x22, and overflow stays 1 until sync_clr.
- FIFO full, the last chunk of 0x44 arrives with word_ready=1 -> pops 0x11 and pushes 0x44 in the same cycle; overflow stays 0.
- TIMEOUT_EN defined, TIMEOUT_CYCLES=16:
  - chunk 0x7, then 16 idle cycles -> timeout_err pulses once;
  - then chunks 0x1, 0x2 -> word_data=0x21.
- Reset mid-word:
  - chunk 0x9, assert rst_n low, release;
  - then chunks 0xC, 0xD -> word_data=0xDC, and no 0x9 remnant appears.
